store_rmw_unit: RTL and testbench
=================================

# store_rmw_unit

Store-side memory access controller for the single-cycle core's data port. It accepts one store request at a time: byte, halfword or word. Sub-word stores run a read-modify-write sequence against a word-addressed data memory. The block reads the containing word, merges the new byte or halfword lanes, and writes the result back. Word stores are written directly. The block sits between the execute/store-op decode and the data memory, and gives the core a ready/done/err handshake for stalling.

## Interface
- `ADDR_WIDTH`, default 32: byte-address width of requests and of `mem_addr`.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  store request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  32  store data, right-aligned: byte in [7:0], half in [15:0].
- `req_op`  in  2  00=SB, 01=SH, 10=SW, 11=treated as SW.
- `mem_addr`  out  ADDR_WIDTH  word-aligned address; bits [1:0] are always 0.
- `mem_rd_en`  out  1  read strobe; exactly one cycle per read.
- `mem_rdata`  in  32  read data.
- `mem_rd_valid`  in  1  read data valid; latency is 1 or more cycles.
- `mem_wr_en`  out  1  write request; held until acknowledged.
- `mem_wdata`  out  32  merged write word.
- `mem_wr_ack`  in  1  write accepted in this cycle.
- `done`  out  1  one-cycle pulse when a store completes.
- `err`  out  1  one-cycle pulse on a misaligned request; nothing is written.

## Operation
- **FSM states:** IDLE, READ, WAIT_RD, WRITE, FIN, FAULT.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, latch addr, wdata and op.
  - Misaligned requests go to FAULT: SH with addr[0]=1, or SW/11 with addr[1:0]≠0.
  - Aligned SW goes to WRITE, with the write word set to `req_wdata`.
  - Aligned SB/SH goes to READ.
- **READ:** `mem_rd_en`=1 and `mem_addr`={addr[ADDR_WIDTH-1:2],2'b00}, then go to WAIT_RD unconditionally.
- **WAIT_RD:**
  - Wait for `mem_rd_valid`.
  - On valid, register the merged word and go to WRITE.
  - Merge for SB: the lane at addr[1:0] (0→[7:0] … 3→[31:24]) takes wdata[7:0]; other lanes keep `mem_rdata`.
  - Merge for SH: addr[1]=0 replaces [15:0]; addr[1]=1 replaces [31:16]. The replacement is wdata[15:0].
- **WRITE:** `mem_wr_en`=1, with `mem_addr` and `mem_wdata` stable. On `mem_wr_ack`, go to FIN.
- **FIN:** `done`=1, go to IDLE.
- **FAULT:** `err`=1, go to IDLE.
- `mem_rd_valid` outside WAIT_RD is ignored.
- `mem_wr_ack` outside WRITE is ignored.
- `mem_rdata` is sampled only in the cycle where `mem_rd_valid`=1.

## Timing
- **Reset values:** state=IDLE, `req_ready`=1, `mem_rd_en`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wdata`=0, `done`=0, `err`=0.
- **Reset mid-operation:** reset asserted in any state drops both enables immediately (asynchronous) and discards the latched request. No partial write is retried.
- **Outputs:** all are registered or decoded from state only. No combinational path from a `mem_*` input to any output.
- **SW latency:**
  - Accept at cycle 0, `mem_wr_en` at cycle 1.
  - `done` comes in the cycle after the ack cycle; with immediate ack, `done` is at cycle 2.
- **SB/SH latency:**
  - Accept at cycle 0, `mem_rd_en` at cycle 1.
  - With read latency L, `mem_rd_valid` arrives at cycle 1+L.
  - `mem_wr_en` follows at cycle 2+L, and `done` comes one cycle after the ack.
- **Misaligned:** `err` at cycle 1, `req_ready` again at cycle 2.
- **Throughput:** `req_ready` reasserts in the cycle after `done`/`err`. A held `req_valid` is accepted then, so there are no idle bubbles beyond FIN/FAULT.
- **Accept condition:** `req_*` is sampled only in the accept cycle. Changes while busy have no effect.

## Structure
- **Shared package:** store-op encodings (STOREOP_SB=2'b00, STOREOP_SH=2'b01, STOREOP_SW=2'b10) and the FSM state encoding. The core decoder uses the same op constants.
- **Sub-module:** one combinational sub-module, `store_lane_merge` (old word, new data, addr[1:0], op → merged word). It holds the lane-replacement rules above and is instantiated once, in WAIT_RD data path.
- **Top level:** holds the FSM, the request latch and the output registers.

## Test plan
- **SW direct write:** SW addr 0x100, data 0xDEADBEEF, ack 2 cycles after `mem_wr_en` rises → `mem_rd_en` never asserts. `mem_addr`=0x100 and `mem_wdata`=0xDEADBEEF stay stable until ack. `done` pulses once.
- **SB merge:** SB addr 0x103, data 0x000000AA, `mem_rdata`=0x11223344 with L=3 → one `mem_rd_en` pulse at 0x100, then `mem_wdata`=0xAA223344.
- **SH merge, both halves:** SH addr 0x102, data 0x00005566, old 0x11223344 → 0x55663344. SH addr 0x100 → 0x11225566.
- **Misaligned:** SH addr 0x101, then SW addr 0x102 → `err` pulses at cycle 1 each. No `mem_rd_en`/`mem_wr_en`. `done` stays 0.
- **Reset mid-read:** `rst_n` low during WAIT_RD, then a stray `mem_rd_valid` after release → all outputs return to reset values. The stray valid causes no write.
- **Back-to-back with stray strobes:** `req_valid` held across SB 0x200 then SW 0x204, with a spurious `mem_wr_ack` pulse during WAIT_RD → second request accepted the cycle after the first `done`. The spurious ack is ignored. Exactly two writes occur.

Source files
------------

// File: rtl/store_rmw_unit_pkg.sv
// Shared store-op encodings and FSM state encoding for the store read-modify-write path.
package store_rmw_unit_pkg;

    localparam logic [1:0] STOREOP_SB = 2'b00;
    localparam logic [1:0] STOREOP_SH = 2'b01;
    localparam logic [1:0] STOREOP_SW = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WAIT_RD = 3'd2,
        ST_WRITE   = 3'd3,
        ST_FIN     = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    // Op 2'b11 falls into the default arm and is checked like a word store.
    function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] addr_lo);
        logic mis;
        case (op)
            STOREOP_SB: mis = 1'b0;
            STOREOP_SH: mis = addr_lo[0];
            default:    mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: replaces the byte/halfword lanes of the old word with the new store data.
module store_lane_merge
    import store_rmw_unit_pkg::*;
(
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_new_data,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_op,
    output logic [31:0] o_merged
);

    // Select replacement lanes from op and the low address bits.
    always_comb begin
        o_merged = i_old_word;
        case (i_op)
            STOREOP_SB: begin
                case (i_addr_lo)
                    2'd0:    o_merged[7:0]   = i_new_data[7:0];
                    2'd1:    o_merged[15:8]  = i_new_data[7:0];
                    2'd2:    o_merged[23:16] = i_new_data[7:0];
                    2'd3:    o_merged[31:24] = i_new_data[7:0];
                    default: o_merged        = i_old_word;
                endcase
            end
            STOREOP_SH: begin
                if (i_addr_lo[1]) begin
                    o_merged[31:16] = i_new_data[15:0];
                end else begin
                    o_merged[15:0]  = i_new_data[15:0];
                end
            end
            default: o_merged = i_new_data;
        endcase
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Store access controller: direct word writes, read-modify-write for byte/halfword stores.
module store_rmw_unit
    import store_rmw_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [1:0]            req_op,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_rd_valid,
    output logic                  mem_wr_en,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_wr_ack,
    output logic                  done,
    output logic                  err
);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_data;
    logic [1:0]            r_op;
    logic [31:0]           r_word;
    logic [31:0]           w_merged;
    logic                  w_accept;

    assign w_accept = (r_state == ST_IDLE) && req_valid;

    store_lane_merge u_merge (
        .i_old_word (mem_rdata),
        .i_new_data (r_data),
        .i_addr_lo  (r_addr[1:0]),
        .i_op       (r_op),
        .o_merged   (w_merged)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!req_valid) begin
                    w_next_state = ST_IDLE;
                end else if (is_misaligned(req_op, req_addr[1:0])) begin
                    w_next_state = ST_FAULT;
                end else if ((req_op == STOREOP_SB) || (req_op == STOREOP_SH)) begin
                    w_next_state = ST_READ;
                end else begin
                    w_next_state = ST_WRITE;
                end
            end
            ST_READ:    w_next_state = ST_WAIT_RD;
            ST_WAIT_RD: begin
                if (mem_rd_valid) begin
                    w_next_state = ST_WRITE;
                end else begin
                    w_next_state = ST_WAIT_RD;
                end
            end
            ST_WRITE: begin
                if (mem_wr_ack) begin
                    w_next_state = ST_FIN;
                end else begin
                    w_next_state = ST_WRITE;
                end
            end
            ST_FIN:   w_next_state = ST_IDLE;
            ST_FAULT: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Request latch and write-word register; the word is overwritten by the merge for sub-word stores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_data <= 32'h0000_0000;
            r_op   <= 2'b00;
            r_word <= 32'h0000_0000;
        end else if (w_accept) begin
            r_addr <= req_addr;
            r_data <= req_wdata;
            r_op   <= req_op;
            r_word <= req_wdata;
        end else if ((r_state == ST_WAIT_RD) && mem_rd_valid) begin
            r_word <= w_merged;
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign mem_rd_en = (r_state == ST_READ);
    assign mem_wr_en = (r_state == ST_WRITE);
    assign done      = (r_state == ST_FIN);
    assign err       = (r_state == ST_FAULT);
    assign mem_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign mem_wdata = r_word;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed bench for store_rmw_unit with an expected-write scoreboard queue.
module tb_store_rmw_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_op;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_rd_valid;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic        mem_wr_ack;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    int rd_cnt  = 0;
    int wr_cnt  = 0;
    int base_rd;
    int base_wr;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    store_rmw_unit #(.ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_op       (req_op),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rdata    (mem_rdata),
        .mem_rd_valid (mem_rd_valid),
        .mem_wr_en    (mem_wr_en),
        .mem_wdata    (mem_wdata),
        .mem_wr_ack   (mem_wr_ack),
        .done         (done),
        .err          (err)
    );

    // Count read strobes and acknowledged writes.
    always @(posedge clk) begin
        if (mem_rd_en) rd_cnt <= rd_cnt + 1;
        if (mem_wr_en && mem_wr_ack) wr_cnt <= wr_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] addr,
                                          input logic [31:0] data, input logic [31:0] old);
        logic [31:0] mask;
        int          sh;
        if (op == 2'b00) begin
            sh   = 8 * addr[1:0];
            mask = 32'h0000_00FF << sh;
        end else if (op == 2'b01) begin
            sh   = addr[1] ? 16 : 0;
            mask = 32'h0000_FFFF << sh;
        end else begin
            return data;
        end
        return (old & ~mask) | ((data << sh) & mask);
    endfunction

    function automatic bit misaligned(input logic [1:0] op, input logic [31:0] addr);
        return ((op == 2'b01) && addr[0]) || (op[1] && (addr[1:0] != 2'b00));
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] old, input bit keep);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = data;
        if (!misaligned(op, addr))
            exp_q.push_back({addr & 32'hFFFF_FFFC, model(op, addr, data, old)});
        tick();
        if (!keep) begin
            req_valid = 1'b0;
            req_op    = 2'b10;
            req_addr  = 32'hFFFF_FFFF;
            req_wdata = 32'h5A5A_5A5A;
        end
    endtask

    task automatic read_phase(input int lat, input logic [31:0] old, input bit spur_ack);
        logic [31:0] wa;
        wa = exp_q[0][63:32];
        chk("rd_en_pulse", {31'd0, mem_rd_en}, 32'd1);
        chk("rd_addr", mem_addr, wa);
        chk("wr_en_during_read", {31'd0, mem_wr_en}, 32'd0);
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        for (int i = 2; i <= lat; i++) begin
            chk("rd_en_single", {31'd0, mem_rd_en}, 32'd0);
            chk("wr_en_wait_rd", {31'd0, mem_wr_en}, 32'd0);
            if (spur_ack && (i == 2)) mem_wr_ack = 1'b1;
            tick();
            mem_wr_ack = 1'b0;
        end
        chk("rd_en_single", {31'd0, mem_rd_en}, 32'd0);
        mem_rd_valid = 1'b1;
        mem_rdata    = old;
        tick();
        mem_rd_valid = 1'b0;
        mem_rdata    = 32'hFFFF_FFFF;
    endtask

    task automatic write_phase(input int ack_dly);
        logic [31:0] ea;
        logic [31:0] ed;
        ea = exp_q[0][63:32];
        ed = exp_q[0][31:0];
        for (int i = 0; i <= ack_dly; i++) begin
            chk("wr_en_held", {31'd0, mem_wr_en}, 32'd1);
            chk("wr_addr", mem_addr, ea);
            chk("wr_data", mem_wdata, ed);
            chk("done_early", {31'd0, done}, 32'd0);
            if (i == ack_dly) mem_wr_ack = 1'b1;
            tick();
        end
        mem_wr_ack = 1'b0;
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("wr_en_after_ack", {31'd0, mem_wr_en}, 32'd0);
        void'(exp_q.pop_front());
        tick();
        chk("done_single", {31'd0, done}, 32'd0);
    endtask

    task automatic misaligned_req(input logic [1:0] op, input logic [31:0] addr);
        issue(op, addr, 32'h1234_5678, 32'h0000_0000, 1'b0);
        chk("err_pulse", {31'd0, err}, 32'd1);
        chk("mis_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("mis_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("mis_done", {31'd0, done}, 32'd0);
        tick();
        chk("err_single", {31'd0, err}, 32'd0);
        chk("ready_after_err", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
        chk({tag, "_wr_en"}, {31'd0, mem_wr_en}, 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'h0000_0000);
        chk({tag, "_wdata"}, mem_wdata, 32'h0000_0000);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_addr     = 32'h0000_0000;
        req_wdata    = 32'h0000_0000;
        req_op       = 2'b00;
        mem_rdata    = 32'h0000_0000;
        mem_rd_valid = 1'b0;
        mem_wr_ack   = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // SW direct write with ack two cycles after wr_en rises.
        base_rd = rd_cnt;
        issue(2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0);
        write_phase(2);
        chk("sw_no_read", rd_cnt, base_rd);

        // SB merge into lane 3, read latency 3.
        base_rd = rd_cnt;
        issue(2'b00, 32'h0000_0103, 32'h0000_00AA, 32'h1122_3344, 1'b0);
        read_phase(3, 32'h1122_3344, 1'b0);
        write_phase(0);
        chk("sb_one_read", rd_cnt, base_rd + 1);

        // SH upper and lower halves.
        issue(2'b01, 32'h0000_0102, 32'h0000_5566, 32'h1122_3344, 1'b0);
        read_phase(1, 32'h1122_3344, 1'b0);
        write_phase(1);
        issue(2'b01, 32'h0000_0100, 32'h0000_5566, 32'h1122_3344, 1'b0);
        read_phase(2, 32'h1122_3344, 1'b0);
        write_phase(0);

        // Op 2'b11 behaves as a word store.
        base_rd = rd_cnt;
        issue(2'b11, 32'h0000_010C, 32'h0BAD_F00D, 32'h0, 1'b0);
        write_phase(0);
        chk("op11_no_read", rd_cnt, base_rd);

        // Misaligned SH and SW.
        base_rd = rd_cnt;
        base_wr = wr_cnt;
        misaligned_req(2'b01, 32'h0000_0101);
        misaligned_req(2'b10, 32'h0000_0102);
        chk("mis_no_reads", rd_cnt, base_rd);
        chk("mis_no_writes", wr_cnt, base_wr);

        // Reset while waiting for read data, then a stray read-valid.
        base_wr = wr_cnt;
        issue(2'b00, 32'h0000_0301, 32'h0000_00C3, 32'h0, 1'b0);
        void'(exp_q.pop_back());
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        tick();
        rst_n = 1'b1;
        tick();
        mem_rd_valid = 1'b1;
        mem_rdata    = 32'h7777_7777;
        tick();
        mem_rd_valid = 1'b0;
        chk("stray_valid_wr_en", {31'd0, mem_wr_en}, 32'd0);
        tick();
        chk("stray_valid_wr_en2", {31'd0, mem_wr_en}, 32'd0);
        chk("stray_valid_ready", {31'd0, req_ready}, 32'd1);
        chk("stray_valid_no_write", wr_cnt, base_wr);

        // Back-to-back with req_valid held and a spurious ack during the read wait.
        base_wr = wr_cnt;
        issue(2'b00, 32'h0000_0200, 32'h0000_007E, 32'hCAFE_BABE, 1'b1);
        req_op    = 2'b10;
        req_addr  = 32'h0000_0204;
        req_wdata = 32'h1234_5678;
        read_phase(3, 32'hCAFE_BABE, 1'b1);
        write_phase(0);
        issue(2'b10, 32'h0000_0204, 32'h1234_5678, 32'h0, 1'b0);
        write_phase(0);
        chk("b2b_two_writes", wr_cnt, base_wr + 2);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
